// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with grant hold and a per-grant hold timeout.
// The registered grant index is held stable so it can drive a one-hot decoder select directly.
module rr_arbiter_8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] req_i,
   input  logic       done_i,
   output logic       gnt_valid_o,
   output logic [2:0] gnt_idx_o,
   output logic       timeout_o
);

   typedef enum logic {IDLE, GRANT} state_e;

   localparam logic       HOLD_EN   = (MAX_HOLD != 0);
   localparam logic [4:0] HOLD_LAST = HOLD_EN ? 5'(MAX_HOLD - 1) : 5'd0;

   state_e     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [4:0] cnt_q, cnt_d;
   logic       gnt_valid_q, gnt_valid_d;
   logic [2:0] gnt_idx_q, gnt_idx_d;
   logic       timeout_q, timeout_d;

   logic [7:0] req_rot;
   logic [2:0] pick_off;
   logic       rel_normal;
   logic       rel_timeout;

   // Rotate requests so the pointer position lands at bit 0; the lowest set bit is the winner.
   always_comb begin
      req_rot  = 8'({req_i, req_i} >> ptr_q);
      pick_off = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (req_rot[i]) pick_off = 3'(i);
      end
   end

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      gnt_valid_d = gnt_valid_q;
      gnt_idx_d   = gnt_idx_q;
      timeout_d   = 1'b0;
      rel_normal  = done_i | ~req_i[gnt_idx_q];
      rel_timeout = HOLD_EN && (cnt_q == HOLD_LAST);
      case (state_q)
         IDLE: begin
            if (|req_i) begin
               gnt_idx_d   = ptr_q + pick_off;
               gnt_valid_d = 1'b1;
               cnt_d       = 5'd0;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            if (rel_normal || rel_timeout) begin
               gnt_valid_d = 1'b0;
               ptr_d       = gnt_idx_q + 3'd1;
               timeout_d   = rel_timeout & ~rel_normal;
               state_d     = IDLE;
            end else if (cnt_q != 5'd31) begin
               // Saturating so an unlimited hold never wraps into a false timeout match.
               cnt_d = cnt_q + 5'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         ptr_q       <= 3'd0;
         cnt_q       <= 5'd0;
         gnt_valid_q <= 1'b0;
         gnt_idx_q   <= 3'd0;
         timeout_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_idx_q   <= gnt_idx_d;
         timeout_q   <= timeout_d;
      end
   end

   assign gnt_valid_o = gnt_valid_q;
   assign gnt_idx_o   = gnt_idx_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios plus random traffic,
// each DUT instance tracked by a cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter_8;

   typedef struct {
      bit busy;
      int owner;
      int held;
      int prio;
      bit timeout;
   } model_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req_a = '0, req_b = '0, req_c = '0;
   logic       done_a = 1'b0, done_b = 1'b0, done_c = 1'b0;
   logic       gv_a, gv_b, gv_c;
   logic [2:0] gi_a, gi_b, gi_c;
   logic       to_a, to_b, to_c;

   model_t ma, mb, mc;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rr_arbiter_8 #(.MAX_HOLD(16)) dut_a (
      .clk_i(clk), .rst_i(rst), .req_i(req_a), .done_i(done_a),
      .gnt_valid_o(gv_a), .gnt_idx_o(gi_a), .timeout_o(to_a));
   rr_arbiter_8 #(.MAX_HOLD(4)) dut_b (
      .clk_i(clk), .rst_i(rst), .req_i(req_b), .done_i(done_b),
      .gnt_valid_o(gv_b), .gnt_idx_o(gi_b), .timeout_o(to_b));
   rr_arbiter_8 #(.MAX_HOLD(0)) dut_c (
      .clk_i(clk), .rst_i(rst), .req_i(req_c), .done_i(done_c),
      .gnt_valid_o(gv_c), .gnt_idx_o(gi_c), .timeout_o(to_c));

   function automatic model_t model_reset();
      model_t m;
      m.busy = 0; m.owner = 0; m.held = 0; m.prio = 0; m.timeout = 0;
      return m;
   endfunction

   // A grant lasts until released by the grantee or until it has been valid max_hold cycles.
   function automatic model_t model_step(model_t m, int max_hold, logic [7:0] req, logic done);
      model_t n = m;
      bit normal, expired, found;
      n.timeout = 0;
      if (!m.busy) begin
         found = 0;
         for (int off = 0; off < 8; off++) begin
            if (!found && req[(m.prio + off) % 8]) begin
               n.owner = (m.prio + off) % 8;
               found   = 1;
            end
         end
         if (found) begin
            n.busy = 1;
            n.held = 1;
         end
      end else begin
         normal  = done || !req[m.owner];
         expired = (max_hold != 0) && (m.held == max_hold);
         if (normal || expired) begin
            n.busy    = 0;
            n.prio    = (m.owner + 1) % 8;
            n.timeout = expired && !normal;
         end else begin
            n.held = m.held + 1;
         end
      end
      return n;
   endfunction

   // Advance one clock edge, update all models from the inputs the DUTs sampled, settle 1 time unit.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         ma = model_reset(); mb = model_reset(); mc = model_reset();
      end else begin
         ma = model_step(ma, 16, req_a, done_a);
         mb = model_step(mb, 4, req_b, done_b);
         mc = model_step(mc, 0, req_c, done_c);
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_a = '0; req_b = '0; req_c = '0;
      done_a = 1'b0; done_b = 1'b0; done_c = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      int exp_idx;
      logic prev_gv;
      tick();
      checks++;
      if ({gv_a, gi_a, to_a, gv_b, gv_c} !== 7'b0) begin
         errors++;
         $display("FAIL reset_state: got gv=%b idx=%0d to=%b, want 0 0 0", gv_a, gi_a, to_a);
      end
      rst = 1'b0;
      req_a = 8'hFF;
      tick();
      tick();
      // Asynchronous reset in the middle of a clock period, checked before any edge.
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({gv_a, gi_a, to_a} !== 5'b0) begin
         errors++;
         $display("FAIL async_reset: got gv=%b idx=%0d to=%b, want 0 0 0", gv_a, gi_a, to_a);
      end
      tick();
      rst = 1'b0;
      exp_idx = 0;
      prev_gv = 1'b0;
      for (int c = 0; c < 18; c++) begin
         tick();
         checks++;
         if ({gv_a, gi_a, to_a} !== {ma.busy, 3'(ma.owner), ma.timeout}) begin
            errors++;
            $display("FAIL rotate_model c=%0d: got %b/%0d/%b, want %b/%0d/%b",
                     c, gv_a, gi_a, to_a, ma.busy, ma.owner, ma.timeout);
         end
         if (gv_a && !prev_gv) begin
            checks++;
            if (gi_a !== 3'(exp_idx)) begin
               errors++;
               $display("FAIL rotate_order: got idx %0d, want %0d", gi_a, exp_idx);
            end
            exp_idx = (exp_idx + 1) % 8;
         end
         prev_gv = gv_a;
         done_a  = gv_a;
      end
      checks++;
      if (exp_idx !== 1) begin
         errors++;
         $display("FAIL rotate_count: sequence ended at next idx %0d, want 1", exp_idx);
      end
   endtask

   task automatic test_rotation_wrap();
      do_reset();
      req_a = 8'h20;
      tick();
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      req_a  = 8'b0010_0010;
      tick();
      checks++;
      if ({gv_a, gi_a} !== {1'b1, 3'd1}) begin
         errors++;
         $display("FAIL wrap_grant: got gv=%b idx=%0d, want 1 1", gv_a, gi_a);
      end
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      tick();
      checks++;
      if ({gv_a, gi_a} !== {1'b1, 3'd5}) begin
         errors++;
         $display("FAIL wrap_next: got gv=%b idx=%0d, want 1 5", gv_a, gi_a);
      end
   endtask

   task automatic test_timeout();
      logic [5:0] exp_gv = 6'b101111;
      logic [5:0] exp_to = 6'b010000;
      do_reset();
      req_b = 8'h01;
      for (int c = 0; c < 6; c++) begin
         tick();
         checks++;
         if ({gv_b, to_b} !== {exp_gv[c], exp_to[c]} || gi_b !== 3'd0) begin
            errors++;
            $display("FAIL timeout c=%0d: got gv=%b to=%b idx=%0d, want %b %b 0",
                     c, gv_b, to_b, gi_b, exp_gv[c], exp_to[c]);
         end
         checks++;
         if ({gv_b, gi_b, to_b} !== {mb.busy, 3'(mb.owner), mb.timeout}) begin
            errors++;
            $display("FAIL timeout_model c=%0d: got %b/%0d/%b, want %b/%0d/%b",
                     c, gv_b, gi_b, to_b, mb.busy, mb.owner, mb.timeout);
         end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      req_b = 8'h01;
      repeat (4) tick();
      done_b = 1'b1;
      tick();
      done_b = 1'b0;
      checks++;
      if ({gv_b, to_b} !== 2'b00) begin
         errors++;
         $display("FAIL simul_release: got gv=%b to=%b, want 0 0", gv_b, to_b);
      end
      tick();
      checks++;
      if (to_b !== 1'b0) begin
         errors++;
         $display("FAIL simul_no_pulse: got to=%b, want 0", to_b);
      end
   endtask

   task automatic test_request_drop();
      do_reset();
      req_a = 8'h08;
      tick();
      tick();
      req_a = 8'h24;
      tick();
      checks++;
      if ({gv_a, gi_a, to_a} !== {1'b0, 3'd3, 1'b0}) begin
         errors++;
         $display("FAIL drop_bubble: got gv=%b idx=%0d to=%b, want 0 3 0", gv_a, gi_a, to_a);
      end
      tick();
      checks++;
      if ({gv_a, gi_a} !== {1'b1, 3'd5}) begin
         errors++;
         $display("FAIL drop_ptr: got gv=%b idx=%0d, want 1 5", gv_a, gi_a);
      end
   endtask

   task automatic test_disabled_timeout();
      int bad = 0;
      do_reset();
      req_c = 8'h40;
      tick();
      for (int c = 0; c < 100; c++) begin
         tick();
         if ({gv_c, gi_c, to_c} !== {1'b1, 3'd6, 1'b0}) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL no_timeout: %0d of 100 cycles not holding idx 6, want 0", bad);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(3) == 0) begin
            req_a = 8'($urandom); req_b = 8'($urandom); req_c = 8'($urandom);
         end
         if ($urandom_range(15) == 0) req_b = 8'h80;
         done_a = ($urandom_range(9) == 0);
         done_b = ($urandom_range(9) == 0);
         done_c = ($urandom_range(9) == 0);
         tick();
         checks++;
         if ({gv_a, gi_a, to_a} !== {ma.busy, 3'(ma.owner), ma.timeout} ||
             {gv_b, gi_b, to_b} !== {mb.busy, 3'(mb.owner), mb.timeout} ||
             {gv_c, gi_c, to_c} !== {mc.busy, 3'(mc.owner), mc.timeout}) begin
            errors++;
            $display("FAIL random c=%0d: a %b/%0d/%b want %b/%0d/%b, b %b/%0d/%b want %b/%0d/%b, c %b/%0d/%b want %b/%0d/%b",
                     c, gv_a, gi_a, to_a, ma.busy, ma.owner, ma.timeout,
                     gv_b, gi_b, to_b, mb.busy, mb.owner, mb.timeout,
                     gv_c, gi_c, to_c, mc.busy, mc.owner, mc.timeout);
         end
      end
   endtask

   initial begin
      ma = model_reset(); mb = model_reset(); mc = model_reset();
      test_reset();
      test_rotation_wrap();
      test_timeout();
      test_simultaneous();
      test_request_drop();
      test_disabled_timeout();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-requester round-robin arbiter with grant hold and a timeout on how long one requester may keep the grant. It sits directly upstream of the 3-to-8 one-hot decoder: `gnt_idx_o` drives the decoder's 3-bit select, and the decoder's one-hot output enables the granted requester's datapath. Fairness comes from a rotating priority pointer. A grant holds until the requester releases it or the hold limit expires.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one grant may stay valid. Legal range 0..31; 0 disables the timeout.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_i`  in  8  request vector; bit n = requester n.
- `done_i`  in  1  current grantee releases its grant this cycle.
- `gnt_valid_o`  out  1  a grant is active.
- `gnt_idx_o`  out  3  binary index of the granted requester (feeds the decoder select).
- `timeout_o`  out  1  one-cycle pulse: the previous grant was forcibly revoked.

## Operation
- State machine with two states, IDLE and GRANT. Internal state:
  - 3-bit priority pointer `ptr`;
  - 5-bit hold counter `cnt`.
- All outputs are registered.
- Reset values:
  - `gnt_valid_o=0`, `gnt_idx_o=3'd0`, `timeout_o=0`;
  - `ptr=0`, `cnt=0`, state IDLE.
- IDLE:
  - If `req_i==0`, stay in IDLE.
  - Otherwise, select the first set bit scanning `ptr`, `ptr+1`, … `ptr+7` (mod 8 wrap).
  - Load `gnt_idx_o` with the selected index, set `gnt_valid_o=1`, clear `cnt`, go to GRANT.
- GRANT: release when any of the following holds at a sampled edge:
  - (a) `done_i=1`;
  - (b) `req_i[gnt_idx_o]=0`;
  - (c) `MAX_HOLD!=0` and `cnt==MAX_HOLD-1`.
- On release:
  - Clear `gnt_valid_o`, set `ptr=gnt_idx_o+1` (mod 8, wraps 7→0), go to IDLE.
  - `timeout_o=1` for the next cycle only if (c) alone caused the release. If (a) or (b) holds on the same edge as (c), it is a normal release and `timeout_o=0`.
- Otherwise stay in GRANT with `cnt` incremented. `cnt` never wraps; `MAX_HOLD` ≤ 31 guarantees this.
- `gnt_idx_o` holds its last value while `gnt_valid_o=0` and never changes during a grant. The downstream decoder therefore sees a stable select.
- `done_i` is ignored in IDLE.
- Requests arriving in GRANT are not registered or queued; they are only sampled in IDLE.
- `timeout_o` is 0 in every cycle except the single cycle after a forced release.

## Timing
- Grant latency is 1 cycle: a request sampled at edge k in IDLE gives `gnt_valid_o=1` after edge k.
- Release:
  - Release condition sampled at edge k gives `gnt_valid_o=0` after edge k.
  - The earliest next grant is after edge k+1, so there is exactly one idle bubble between grants.
- Maximum grant length is `MAX_HOLD` cycles with `gnt_valid_o=1`.
- Worst-case wait for a continuously requesting input is 8×(`MAX_HOLD`+1) cycles.
- Reset asserted mid-grant clears all outputs and state immediately, without waiting for a clock edge. The first grant after reset release starts from `ptr=0`.
- `timeout_o` is asserted in the same cycle as the IDLE bubble and coincides with `gnt_valid_o=0`.

## Test plan
- **Reset and priority:**
  - Stimulus: assert `rst_i` during a grant, then release it, with `req_i=8'hFF`.
  - Required response: outputs go to 0 asynchronously; first grant is idx 0; after `done_i`, idx 1, then 2 … 7, then 0. Each grant is separated by one bubble.
- **Rotation skip and wrap:**
  - Stimulus: `ptr=6`, `req_i=8'b0010_0010`.
  - Required response: grant idx 1 (wraps past 7). After release, `ptr=2` and the next grant is idx 5.
- **Timeout:**
  - Stimulus: `MAX_HOLD=4`, `req_i=8'h01` held, `done_i=0`.
  - Required response: `gnt_valid_o` is high for exactly 4 cycles, then `timeout_o=1` for 1 cycle, then idx 0 is granted again.
- **Simultaneous release:**
  - Stimulus: `MAX_HOLD=4`; assert `done_i` in the 4th grant cycle.
  - Required response: normal release with `timeout_o=0`.
- **Request drop:**
  - Stimulus: grantee idx 3 deasserts `req_i[3]` mid-grant with `done_i=0`.
  - Required response: `gnt_valid_o` falls the next cycle; `gnt_idx_o` stays 3 during the bubble; `ptr=4`.
- **Disabled timeout:**
  - Stimulus: `MAX_HOLD=0`, one requester held for 100 cycles.
  - Required response: the grant stays valid for all 100 cycles; `timeout_o` never asserts.
